// File: rtl/deser_pkg.sv
// deser_pkg
// ---------
// Shared types and helpers for the serial_deser receiver.
//   deser_state_t   : receiver FSM states (PARITY is only reachable when the
//                     DESER_PARITY_EN macro is defined)
//   count_width()   : width of the bit counter, clog2(WIDTH)+1, wide enough
//                     to hold the value WIDTH itself

package deser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECV   = 2'd1,
        PARITY = 2'd2
    } deser_state_t;

    // The extra bit lets the counter reach WIDTH without wrapping.
    function automatic int count_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/serial_deser_if.sv
// serial_deser_if
// ---------------
// Bundles the serial input stream and the parallel valid/ready output of the
// serial_deser receiver.
//   Start, Bit_In, Bit_Valid : serial frame input (driven by the master)
//   Data_Ready               : downstream accepts Data_Out (driven by the master)
//   Data_Out, Data_Valid     : assembled word and its valid flag (driven by the slave)
//   Busy, Overrun, Parity_Err: status (driven by the slave)
// Modports:
//   master : the side that feeds bits and consumes words (bench / upstream)
//   slave  : the receiver itself

interface serial_deser_if #(
    parameter int WIDTH = 8
);

    logic             Start;
    logic             Bit_In;
    logic             Bit_Valid;
    logic             Data_Ready;
    logic [WIDTH-1:0] Data_Out;
    logic             Data_Valid;
    logic             Busy;
    logic             Overrun;
    logic             Parity_Err;

    modport master (
        output Start,
        output Bit_In,
        output Bit_Valid,
        output Data_Ready,
        input  Data_Out,
        input  Data_Valid,
        input  Busy,
        input  Overrun,
        input  Parity_Err
    );

    modport slave (
        input  Start,
        input  Bit_In,
        input  Bit_Valid,
        input  Data_Ready,
        output Data_Out,
        output Data_Valid,
        output Busy,
        output Overrun,
        output Parity_Err
    );

endinterface

// File: rtl/deser_out_slot.sv
// deser_out_slot
// --------------
// Single-entry output holding register with a valid/ready handshake.
// A completed word is accepted when the slot is empty or is being emptied on
// the same edge; otherwise the new word is dropped and the sticky overrun
// flag is raised (cleared only by Reset).
// Ports:
//   Clk, Reset      : clock and synchronous active-high reset
//   word_valid      : a completed word is offered this cycle
//   word_in         : the completed word
//   word_perr       : parity mismatch for word_in (0 when parity is unused)
//   data_ready      : downstream accepts data_out this cycle
//   data_out        : held word
//   data_valid      : data_out holds an unconsumed word
//   overrun         : sticky, a completed word was dropped
//   parity_err      : parity flag belonging to the word in data_out

module deser_out_slot #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             word_valid,
    input  logic [WIDTH-1:0] word_in,
    input  logic             word_perr,
    input  logic             data_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             overrun,
    output logic             parity_err
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             perr_q, perr_d;

    logic             consume;
    logic             slot_free;

    assign consume   = valid_q && data_ready;
    // A word leaving on this edge frees the slot for a word arriving on it.
    assign slot_free = !valid_q || consume;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            perr_q    <= perr_d;
        end
    end

    // Data_Out keeps its last value after a transfer; only the valid flag drops.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        perr_d    = perr_q;

        if (word_valid && slot_free) begin
            data_d  = word_in;
            perr_d  = word_perr;
            valid_d = 1'b1;
        end else if (word_valid) begin
            overrun_d = 1'b1;
        end else if (consume) begin
            valid_d = 1'b0;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign overrun    = overrun_q;
    assign parity_err = perr_q;

endmodule

// File: rtl/serial_deser.sv
// serial_deser
// ------------
// Serial-in, parallel-out receiver for LSB-first frames of WIDTH bits.
// Bits qualified by Bit_Valid are shifted in from the top so that the first
// bit received ends up in bit 0. Completed words go to deser_out_slot, which
// provides the registered valid/ready output and overrun detection.
// Optional feature (macro DESER_PARITY_EN): after the data bits one extra
// even-parity bit is received; Parity_Err reports a mismatch for the word in
// Data_Out. Without the macro there is no parity state and Parity_Err is 0.
// Ports:
//   Clk   : system clock, all state changes on posedge
//   Reset : synchronous, active-high
//   bus   : serial_deser_if slave modport
//           (Start, Bit_In, Bit_Valid, Data_Ready in;
//            Data_Out, Data_Valid, Busy, Overrun, Parity_Err out)

module serial_deser
    import deser_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           Clk,
    input  logic           Reset,
    serial_deser_if.slave  bus
);

    localparam int CW = count_width(WIDTH);

    deser_state_t     state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;

    logic             word_done;
    logic [WIDTH-1:0] word;
    logic             word_perr;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            count_q <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            shreg_q <= shreg_d;
        end
    end

    // Start wins over everything else: it abandons any frame in flight
    // silently and may carry bit 0 of the new frame in the same cycle.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        shreg_d   = shreg_q;
        word_done = 1'b0;
        word      = shreg_q;
        word_perr = 1'b0;

        if (bus.Start) begin
            state_d = RECV;
            count_d = '0;
            shreg_d = '0;
            if (bus.Bit_Valid) begin
                shreg_d = {bus.Bit_In, {(WIDTH-1){1'b0}}};
                count_d = CW'(1);
            end
        end else begin
            case (state_q)
                RECV: begin
                    if (bus.Bit_Valid) begin
                        shreg_d = {bus.Bit_In, shreg_q[WIDTH-1:1]};
                        count_d = count_q + CW'(1);
                        if (count_q == CW'(WIDTH-1)) begin
`ifdef DESER_PARITY_EN
                            state_d = PARITY;
`else
                            state_d   = IDLE;
                            word_done = 1'b1;
                            word      = shreg_d;
`endif
                        end
                    end
                end
`ifdef DESER_PARITY_EN
                // Even parity: data bits xor parity bit must be zero.
                PARITY: begin
                    if (bus.Bit_Valid) begin
                        state_d   = IDLE;
                        word_done = 1'b1;
                        word      = shreg_q;
                        word_perr = (^shreg_q) ^ bus.Bit_In;
                    end
                end
`endif
                default: begin
                    // IDLE: stray Bit_Valid strobes are ignored.
                end
            endcase
        end
    end

    deser_out_slot #(
        .WIDTH (WIDTH)
    ) u_out_slot (
        .Clk        (Clk),
        .Reset      (Reset),
        .word_valid (word_done),
        .word_in    (word),
        .word_perr  (word_perr),
        .data_ready (bus.Data_Ready),
        .data_out   (bus.Data_Out),
        .data_valid (bus.Data_Valid),
        .overrun    (bus.Overrun),
        .parity_err (bus.Parity_Err)
    );

    assign bus.Busy = (state_q != IDLE);

endmodule

// File: doc/serial_deser.md
# serial_deser

Serial-in, parallel-out receiver for the LSB-first bit stream produced by the team's right-shifting parallel-load registers, which emit bit 0 first. Collects a framed word of WIDTH bits qualified by a per-bit strobe and presents it on a registered output with a valid/ready handshake. It sits at the far end of any shift-out datapath, for example results streamed from the shift-add multiplier, and converts the stream back to parallel words for downstream logic.

## Interface
- WIDTH, 8: data bits per frame, at least 2.
- Clk  input  1  system clock; all state updates on posedge.
- Reset  input  1  synchronous, active-high.
- Start  input  1  frame start pulse; begins a new frame.
- Bit_In  input  1  serial data bit.
- Bit_Valid  input  1  Bit_In is sampled this cycle.
- Data_Ready  input  1  downstream accepts Data_Out.
- Data_Out  output  WIDTH  assembled word, held while Data_Valid=1.
- Data_Valid  output  1  Data_Out is valid.
- Busy  output  1  a frame is in progress (state is not IDLE).
- Overrun  output  1  sticky flag: a completed word was dropped.
- Parity_Err  output  1  parity mismatch for the word currently in Data_Out.

## Operation
- Reset values: Data_Out=0, Data_Valid=0, Busy=0, Overrun=0, Parity_Err=0; state=IDLE; bit count=0; shift register=0.
- States:
  - IDLE -> RECV on Start.
  - RECV -> IDLE (or PARITY) on the last data bit.
  - PARITY -> IDLE on the parity bit. PARITY exists only with the macro.
- Start clears the bit count and shift register. If Bit_Valid is also high in the Start cycle, that bit is accepted as bit 0.
- Start during RECV or PARITY abandons the current frame: no output and no flag; a new frame begins.
- Bit_Valid in IDLE is ignored.
- Each accepted bit in RECV: shreg <= {Bit_In, shreg[WIDTH-1:1]}; count increments.
- On the accepted bit with count==WIDTH-1 (no parity), the word is complete:
  - If the output slot is free, or is being consumed this cycle (Data_Valid && Data_Ready): load Data_Out, set Data_Valid=1.
  - Otherwise: keep the old Data_Out, discard the new word, set Overrun=1.
- Handshake:
  - Transfer occurs at a posedge where Data_Valid && Data_Ready.
  - Data_Valid clears on the next cycle unless a new word loads on the same edge.
  - Data_Out is stable while Data_Valid=1 and Data_Ready=0.
- Overrun stays set until Reset.
- Bit count is clog2(WIDTH)+1 bits wide; it never wraps because every frame ends at WIDTH bits.

## Timing
- Latency: Data_Valid and Data_Out are visible on the cycle after the edge that samples the final bit (parity bit when enabled).
- Back-to-back frames: Start may be asserted in the cycle right after completion; no dead cycle is required.
- Bit_Valid may be held high continuously for one bit per clock.
- Reset mid-frame or mid-handshake returns every output to its reset value on the next edge.

## Configuration
- DESER_PARITY_EN defined:
  - After WIDTH data bits, the FSM enters PARITY and takes one further Bit_Valid bit as even parity, so ^data ^ parity must equal 0.
  - Parity_Err is loaded together with Data_Out: 1 on mismatch.
  - The word is delivered regardless of Parity_Err.
  - Overrun rules apply at the parity bit.
- DESER_PARITY_EN undefined: no PARITY state; completion happens at data bit WIDTH-1; Parity_Err is tied to 0.

## Structure
- Shared package deser_pkg:
  - state enum deser_state_t {IDLE, RECV, PARITY}.
  - function for the count width, clog2(WIDTH)+1.
- One sub-module, deser_out_slot: the output holding register implementing the valid/ready slot and Overrun detection.
- FSM, bit counter and shift register live in serial_deser.

## Test plan
- WIDTH=8: Start with bit 0, then bits 1,0,1,0,0,1,0,1 one per clock, Data_Ready=1 -> Data_Out=0xA5 with Data_Valid=1 for exactly one cycle, one clock after the last bit.
- Gaps between strobes: 0x3C sent with Bit_Valid low on alternate cycles -> Data_Out=0x3C; no change to Data_Out while Bit_Valid is low.
- Data_Ready=0: send 0x11 then 0x22 -> Data_Out stays 0x11, Overrun=1. Raise Data_Ready -> 0x11 transfers and Data_Valid drops; Overrun stays 1.
- Start after 3 bits of 0xFF, then a full 0x5A frame -> only 0x5A delivered, Overrun=0.
- Reset asserted after 5 bits -> next cycle Busy=0, Data_Valid=0, all outputs 0. A subsequent 0x81 frame is delivered correctly.
- With DESER_PARITY_EN: 0x07 with parity bit 1 -> Parity_Err=0. 0x07 with parity bit 0 -> Parity_Err=1 and Data_Out=0x07.
